mod_accum_pipe: RTL and testbench
=================================

# mod_accum_pipe

Pipelined, parametrised modular-arithmetic unit for the regression arithmetic blocks. It reduces a `W_IN`-bit input modulo `MODULUS` and then applies one of four modes: add a constant offset, subtract it, accumulate into a running residue, or clear. Its predecessor was a single combinational (x mod 20 + 6) mod 20 path. This block adds selectable modes, a persistent accumulator, valid/ready flow control and a two-stage pipeline, so it can sit between streaming producer and consumer stages.

## Interface
Parameters:
- `W_IN`, default 7: input data width.
- `MODULUS`, default 20: modulus M. Legal range 2 ≤ M ≤ 2^W_IN.
- `OFFSET`, default 6: constant K used by ADD and SUB. Legal range 0 ≤ K < M.
- `W_OUT`, default `$clog2(MODULUS)`: residue width. Derived; do not override.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input beat present.
- `in_ready`, out, 1: block accepts a beat this cycle.
- `in_data`, in, W_IN: operand, unsigned.
- `in_mode`, in, 2: 0=ADD, 1=SUB, 2=ACC, 3=CLR.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, W_OUT: result residue, always < M.
- `acc_value`, out, W_OUT: current accumulator contents.

## Operation
- Stage 1 (`s1`):
  - r = in_data mod M, registered with the mode.
  - All arithmetic is unsigned and evaluated at width W_IN+1; there is no truncation before reduction.
- Stage 2 (`s2`): computes from r and the mode.
  - ADD: out = r+K, then subtract M if ≥ M.
  - SUB: out = r−K, then add M if negative.
  - ACC: acc ← (acc+r) reduced by one conditional subtract; out = the new acc.
  - CLR: acc ← 0, out = 0. in_data is ignored.
- Correctness rests on r < M and acc < M. Exactly one conditional correction is therefore sufficient, and only stage 1 uses a true modulo.
- The accumulator updates only when a beat transfers s1→s2. ADD and SUB never modify acc.
- Flow control:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free, combinational.
  - s1 advances to s2 when s1_valid && s2_free.
- Beats are never dropped or duplicated, and order is preserved.
- out_data and out_valid hold stable while out_valid && !out_ready.

## Timing
- Reset (rst=0, asynchronous): s1_valid=0, out_valid=0, out_data=0, acc_value=0.
  - in_ready=1 once reset is released. It is combinationally 1 during reset.
  - Any beat in flight is discarded. The first transfer is allowed on the first rising edge with rst=1.
- Latency: a beat accepted at edge n produces out_valid=1 after edge n+1, provided there is no back-pressure.
- Throughput: one beat per cycle while out_ready=1.
- Back-pressure with out_ready held low:
  - The first accepted beat fills s2, the second fills s1, then in_ready=0.
  - Two beats are buffered at most.
- Simultaneous events:
  - An output transfer and an s1→s2 move may occur on the same edge.
  - An input transfer and an s1→s2 move may occur on the same edge.
  - Both are required to work at full rate.
- Back-to-back ACC beats each see the acc value written by the previous beat, with no hazard bubble.
- acc_value reflects the registered accumulator. It changes on the same edge as out_data for ACC and CLR beats.

## Structure
- Package `mod_pkg`:
  - enum `mode_t`: MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR.
  - parametrised functions `mod_add1` and `mod_sub1` (single conditional correction).
- Sub-module `mod_reduce`:
  - combinational, W_IN → W_OUT, computes in_data mod M.
  - instantiated in stage 1 and reusable by other blocks.
- Top: two stage registers with valid bits, the accumulator register, and handshake logic.

## Test plan
All scenarios use the defaults (M=20, K=6, W_IN=7) unless stated.
- Reset and ADD:
  - Release rst, then ADD in_data=127 → out_data=13 two edges later.
  - ADD in_data=19 → 5.
  - ADD in_data=0 → 6.
- SUB wrap: SUB with in_data=2 → 16, and with in_data=6 → 0.
- ACC chain:
  - CLR, then ACC 15, 15, 15 back-to-back with out_ready=1.
  - Expect out_data = 0, 15, 10, 5 on consecutive cycles.
  - Final acc_value = 5.
- Back-pressure:
  - Hold out_ready=0 and offer ADD 1, 2, 3.
  - in_ready drops after 2 accepts.
  - Release out_ready → outputs 7, 8, 9 in order, with no loss or duplication.
- Reset mid-operation:
  - Assert rst asynchronously with both stages full and acc=12.
  - Outputs go to 0 immediately.
  - After release, ACC 4 → 4.
- Parameter sweep:
  - M=2^W_IN (W_IN=4, M=16, K=15): ADD 15 → 14.
  - Randomised stream checked against a scoreboard model with random out_ready.

Source files
------------

// File: rtl/mod_pkg.sv
// mod_pkg: shared definitions for the modular-arithmetic blocks.
//   mode_t   - operation selector (ADD, SUB, ACC, CLR)
//   mod_add1 - (a + b) mod m, assuming a < m and b < m
//   mod_sub1 - (a - b) mod m, assuming a < m and b < m
// The helpers work on MOD_W-bit operands with the modulus as an argument,
// so callers of any width cast in and truncate the result back out.
package mod_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ACC = 2'd2,
        MODE_CLR = 2'd3
    } mode_t;

    localparam int unsigned MOD_W = 32;

    // Single conditional subtract; valid only because both operands are < m.
    function automatic logic [MOD_W-1:0] mod_add1(
        input logic [MOD_W-1:0] a,
        input logic [MOD_W-1:0] b,
        input logic [MOD_W-1:0] m
    );
        logic [MOD_W-1:0] s;
        s = a + b;
        if (s >= m) begin
            s = s - m;
        end
        return s;
    endfunction

    // Single conditional add-back; valid only because both operands are < m.
    function automatic logic [MOD_W-1:0] mod_sub1(
        input logic [MOD_W-1:0] a,
        input logic [MOD_W-1:0] b,
        input logic [MOD_W-1:0] m
    );
        logic [MOD_W-1:0] s;
        if (a >= b) begin
            s = a - b;
        end else begin
            s = (a + m) - b;
        end
        return s;
    endfunction

endpackage

// File: rtl/mod_reduce.sv
// mod_reduce: combinational in_data mod MODULUS.
//   in_data - W_IN-bit unsigned operand
//   residue - W_OUT-bit result, always < MODULUS
// The operand and modulus are both carried at W_IN+1 bits so that
// MODULUS == 2**W_IN is representable without truncation.
module mod_reduce #(
    parameter int W_IN    = 7,
    parameter int MODULUS = 20,
    parameter int W_OUT   = $clog2(MODULUS)
) (
    input  logic [W_IN-1:0]  in_data,
    output logic [W_OUT-1:0] residue
);

    localparam int WE = W_IN + 1;

    logic [WE-1:0] ext;
    logic [WE-1:0] m_ext;

    always_comb begin
        ext     = {1'b0, in_data};
        m_ext   = WE'(MODULUS);
        residue = W_OUT'(ext % m_ext);
    end

endmodule

// File: rtl/mod_accum_pipe.sv
// mod_accum_pipe: two-stage modular arithmetic pipeline with accumulator.
//   clk, rst        - clock; asynchronous active-low reset
//   in_valid/ready  - input handshake; in_data operand, in_mode op select
//   out_valid/ready - output handshake; out_data residue (< MODULUS)
//   acc_value       - registered accumulator contents
// Stage 1 holds in_data mod MODULUS plus the mode; stage 2 is the output
// register. The accumulator is written only on an s1->s2 move, so
// back-to-back ACC beats chain through it without a bubble.
module mod_accum_pipe
    import mod_pkg::*;
#(
    parameter int W_IN    = 7,
    parameter int MODULUS = 20,
    parameter int OFFSET  = 6,
    parameter int W_OUT   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_data,
    output logic [W_OUT-1:0] acc_value
);

    logic             s1_valid;
    logic [W_OUT-1:0] s1_r;
    mode_t            s1_mode;
    logic [W_OUT-1:0] in_r;
    logic [W_OUT-1:0] acc;
    logic [W_OUT-1:0] acc_next;
    logic [W_OUT-1:0] s2_data;
    logic             s2_free;
    logic             in_fire;
    logic             s1_move;

    mod_reduce #(
        .W_IN    (W_IN),
        .MODULUS (MODULUS),
        .W_OUT   (W_OUT)
    ) u_reduce (
        .in_data (in_data),
        .residue (in_r)
    );

    always_comb begin
        s2_free  = !out_valid || out_ready;
        in_ready = !s1_valid || s2_free;
        in_fire  = in_valid && in_ready;
        s1_move  = s1_valid && s2_free;
    end

    always_comb begin
        s2_data  = '0;
        acc_next = acc;
        case (s1_mode)
            MODE_ADD: s2_data = W_OUT'(mod_add1(MOD_W'(s1_r), MOD_W'(OFFSET), MOD_W'(MODULUS)));
            MODE_SUB: s2_data = W_OUT'(mod_sub1(MOD_W'(s1_r), MOD_W'(OFFSET), MOD_W'(MODULUS)));
            MODE_ACC: begin
                acc_next = W_OUT'(mod_add1(MOD_W'(acc), MOD_W'(s1_r), MOD_W'(MODULUS)));
                s2_data  = acc_next;
            end
            MODE_CLR: begin
                acc_next = '0;
                s2_data  = '0;
            end
            default: begin
                acc_next = acc;
                s2_data  = '0;
            end
        endcase
    end

    // Stage 1: a new beat may load on the same edge the old one leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_mode  <= MODE_ADD;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_r     <= in_r;
            s1_mode  <= mode_t'(in_mode);
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 and accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
        end else if (s1_move) begin
            out_valid <= 1'b1;
            out_data  <= s2_data;
            acc       <= acc_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign acc_value = acc;

endmodule

// File: tb/tb_mod_accum_pipe.sv
// tb_mod_accum_pipe: scoreboard bench for mod_accum_pipe.
// Instance a uses the defaults (M=20, K=6, W_IN=7); instance b uses
// W_IN=4, M=16, K=15. Drivers push expected {out_data, acc_value} pairs
// when a beat is accepted; per-instance monitors pop and compare on
// every output transfer.
module tb_mod_accum_pipe;

    logic clk;
    logic rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [6:0] a_in_data;
    logic [1:0] a_in_mode;
    logic [4:0] a_out_data, a_acc_value;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_in_data;
    logic [1:0] b_in_mode;
    logic [3:0] b_out_data, b_acc_value;

    int checks = 0;
    int passes = 0;
    int qa_d[$], qa_a[$], qb_d[$], qb_a[$];
    int a_pop_cyc[$];
    int cyc = 0;
    int mdl_acc;
    bit rnd_on;
    bit a_stall_prev = 0;
    int a_prev_data  = 0;

    mod_accum_pipe u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .acc_value (a_acc_value)
    );

    mod_accum_pipe #(
        .W_IN    (4),
        .MODULUS (16),
        .OFFSET  (15)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .acc_value (b_acc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor for instance a, including the hold-while-stalled rule.
    always @(negedge clk) begin
        if (!rst) begin
            a_stall_prev = 0;
        end else begin
            if (a_stall_prev) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out_data, a_prev_data);
            end
            if (a_out_valid && a_out_ready) begin
                if (qa_d.size() == 0) begin
                    check("a_unexpected_output", a_out_data, -1);
                end else begin
                    check("a_out_data", a_out_data, qa_d.pop_front());
                    check("a_acc_value", a_acc_value, qa_a.pop_front());
                    a_pop_cyc.push_back(cyc);
                end
            end
            a_stall_prev = a_out_valid && !a_out_ready;
            a_prev_data  = a_out_data;
        end
    end

    always @(negedge clk) begin
        if (rst && b_out_valid && b_out_ready) begin
            if (qb_d.size() == 0) begin
                check("b_unexpected_output", b_out_data, -1);
            end else begin
                check("b_out_data", b_out_data, qb_d.pop_front());
                check("b_acc_value", b_acc_value, qb_a.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(input int mode, input int data, input int ed, input int ea);
        int n;
        a_in_mode  = 2'(mode);
        a_in_data  = 7'(data);
        a_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!a_in_ready) check("a_in_ready_timeout", 0, 1);
        else begin
            qa_d.push_back(ed);
            qa_a.push_back(ea);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input int mode, input int data, input int ed, input int ea);
        int n;
        b_in_mode  = 2'(mode);
        b_in_data  = 4'(data);
        b_in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!b_in_ready) check("b_in_ready_timeout", 0, 1);
        else begin
            qb_d.push_back(ed);
            qb_a.push_back(ea);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit is_b);
        int n;
        n = 0;
        @(negedge clk);
        while (((is_b ? qb_d.size() : qa_d.size()) != 0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(is_b ? "b_drain_timeout" : "a_drain_timeout",
              is_b ? qb_d.size() : qa_d.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d, m, r, ed;

        rst = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
        b_in_valid = 0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;

        // Reset state.
        #3;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_acc", a_acc_value, 0);
        check("rst_in_ready", a_in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;

        // ADD / SUB with latency check on the first beat.
        send_a(0, 127, 13, 0);
        check("lat_edge_n", a_out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge_n1", a_out_valid, 1);
        send_a(0, 19, 5, 0);
        send_a(0, 0, 6, 0);
        send_a(1, 2, 16, 0);
        send_a(1, 6, 0, 0);
        wait_drain(0);

        // ACC chain at full rate.
        a_pop_cyc.delete();
        send_a(3, 0, 0, 0);
        send_a(2, 15, 15, 15);
        send_a(2, 15, 10, 10);
        send_a(2, 15, 5, 5);
        wait_drain(0);
        if (a_pop_cyc.size() == 4) check("acc_chain_span", a_pop_cyc[3] - a_pop_cyc[0], 3);
        else check("acc_chain_count", a_pop_cyc.size(), 4);
        check("acc_final", a_acc_value, 5);

        // Back-pressure: two beats buffered, then in_ready drops.
        a_out_ready = 1'b0;
        send_a(0, 1, 7, 5);
        send_a(0, 2, 8, 5);
        a_in_mode = 2'd0; a_in_data = 7'd3; a_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", a_in_ready, 0);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        send_a(0, 3, 9, 5);
        wait_drain(0);

        // Asynchronous reset with both stages full and acc = 12.
        send_a(3, 0, 0, 0);
        send_a(2, 12, 12, 12);
        wait_drain(0);
        a_out_ready = 1'b0;
        send_a(0, 1, 7, 12);
        send_a(0, 2, 8, 12);
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", a_out_valid, 1);
        check("pre_rst_in_ready", a_in_ready, 0);
        check("pre_rst_acc", a_acc_value, 12);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", a_out_valid, 0);
        check("mid_rst_out_data", a_out_data, 0);
        check("mid_rst_acc", a_acc_value, 0);
        check("mid_rst_in_ready", a_in_ready, 1);
        qa_d.delete();
        qa_a.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        send_a(2, 4, 4, 4);
        wait_drain(0);

        // Random stream with random back-pressure.
        send_a(3, 0, 0, 0);
        mdl_acc = 0;
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    d = int'($urandom_range(0, 127));
                    m = int'($urandom_range(0, 3));
                    r = d % 20;
                    case (m)
                        0: ed = (r + 6) % 20;
                        1: ed = (r + 20 - 6) % 20;
                        2: begin mdl_acc = (mdl_acc + r) % 20; ed = mdl_acc; end
                        default: begin mdl_acc = 0; ed = 0; end
                    endcase
                    send_a(m, d, ed, mdl_acc);
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    a_out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        a_out_ready = 1'b1;
        wait_drain(0);

        // M = 2**W_IN instance: M=16, K=15.
        send_b(0, 15, 14, 0);
        send_b(1, 0, 1, 0);
        send_b(2, 15, 15, 15);
        send_b(2, 15, 14, 14);
        send_b(0, 0, 15, 14);
        wait_drain(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
